dvsd_8216m2_acc: RTL
====================

Name: dvsd_8216m2_acc

Overview:
Sequential accumulator stage directly downstream of the 8x8 Wallace-tree multiplier. It consumes the 16-bit product stream with a valid/ready handshake and sums products into a frame. It emits one registered sum per frame, with a term count and a sticky overflow flag. This turns the combinational multiplier into a dot-product / MAC datapath.

Parameters:
ACC_W, 24, accumulator and output sum width in bits (17..32)
N_TERMS, 8, maximum products per frame; the frame closes automatically at this count (1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  product on in_m is valid this cycle
in_ready  output  1  block accepts a product this cycle
in_m  input  16  unsigned product {m15..m0} from the multiplier
in_last  input  1  qualified by in_valid; the accepted product closes the frame
out_valid  output  1  frame result is available
out_ready  input  1  downstream accepts the result
out_sum  output  ACC_W  frame sum, modulo 2^ACC_W
out_count  output  8  number of products in the frame
out_ovf  output  1  sticky; a carry out of ACC_W occurred in this frame

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock and reset ports are named clk and rst.
- Reset, sampled at a rising edge while rst=1:
  - state <= ACC; acc <= 0; cnt <= 0; ovf <= 0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- in_ready = (state==ACC) && !rst, so it reads 0 while rst is high.
- Reset overrides any handshake in the same cycle. A partial frame is discarded and never emitted.
- States: ACC (collecting products) and OUT (holding a result).
- ACC state:
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - On a transfer: {carry, acc} <= acc + zero-extended in_m; cnt <= cnt+1; ovf <= ovf | carry.
  - acc wraps modulo 2^ACC_W. ovf is never cleared inside a frame.
  - If the transfer makes cnt+1 == N_TERMS, or in_last=1, the state goes to OUT on the same edge. The updated acc, cnt and ovf become out_sum, out_count and out_ovf.
  - in_last=1 on the N_TERMS-th product closes the frame exactly once.
  - in_last with in_valid=0 is ignored.
  - With no transfer, all registers hold.
- OUT state:
  - out_valid=1 and in_ready=0. out_sum, out_count and out_ovf are stable until the handshake completes.
  - On out_valid && out_ready at an edge: state <= ACC; acc, cnt and ovf <= 0; out_valid <= 0.
  - out_sum, out_count and out_ovf then return to 0.
  - The next product can be accepted in the cycle after the handshake. This one-cycle bubble is required; there is no same-cycle pass-through.
- Latency: the result is visible on the outputs one cycle after the edge that accepted the closing product.
- Outputs are driven only by registers or state; there is no combinational path from in_* to out_*.
- in_m is treated as unsigned. Maximum single product is 255*255 = 65025 (0xFE01). At default parameters no overflow is possible: 8*65025 = 520200 < 2^24.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. The first product after release starts a fresh frame.
- Full frame, defaults: 8 back-to-back products of 0xFE01 with out_ready=1 -> the cycle after the 8th accept shows out_valid=1, out_sum=0x07F008 (520200), out_count=8, out_ovf=0.
- Early close: products 6, 100, 1 with in_last on the third -> out_sum=107, out_count=3. The next frame starts from acc=0 after the handshake.
- Backpressure: hold out_ready=0 for 5 cycles in OUT while in_valid=1 -> outputs stable, in_ready=0, no product absorbed. After out_ready=1, the next accepted value 9 yields a frame starting at 9.
- Overflow with ACC_W=17, N_TERMS=3: three products of 65025 -> out_sum=64003 (195075 mod 131072), out_count=3, out_ovf=1. The following frame shows out_ovf=0.
- Reset mid-frame: accept 500 and 700, pulse rst for one cycle, then send 5 with in_last -> out_sum=5, out_count=1. No result is emitted for the aborted frame.

Source files
------------

// File: rtl/dvsd_8216m2_acc.sv
// dvsd_8216m2_acc: frame accumulator for the multiplier product stream with valid/ready handshakes
module dvsd_8216m2_acc #(
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_m,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);
    typedef enum logic {ACC, OUT} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf;
    logic [ACC_W:0]   sum;
    logic [7:0]       cnt_nx;
    logic             ovf_nx;
    logic             xfer;
    logic             close;

    assign in_ready = (state == ACC) && !rst;
    assign xfer     = in_valid && in_ready;
    assign sum      = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, in_m};
    assign cnt_nx   = cnt + 8'd1;
    assign ovf_nx   = ovf | sum[ACC_W];
    assign close    = (cnt_nx == 8'(N_TERMS)) || in_last;

    // collect products in ACC, hold the closed frame's result in OUT until it is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (state == ACC) begin
            if (xfer) begin
                acc <= sum[ACC_W-1:0];
                cnt <= cnt_nx;
                ovf <= ovf_nx;
                if (close) begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                    out_sum   <= sum[ACC_W-1:0];
                    out_count <= cnt_nx;
                    out_ovf   <= ovf_nx;
                end
            end
        end else if (out_ready) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end
    end
endmodule
